id_ex_stage_reg: RTL and testbench

ID/EX pipeline register for the 5-stage MIPS32 core with integrated load-use hazard detection. It captures decoded control, operands and register specifiers from ID and presents them to EX, including the rs/rt/write-address fields consumed by the EX forwarding unit. It inserts one-cycle bubbles on load-use hazards and branch flushes, and freezes on external (memory) stalls.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/load_use_hazard_detect.sv | 43 ++++
 rtl/id_ex_stage_reg.sv | 137 +++++++++++++
 tb/tb_id_ex_stage_reg.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 5-stage core pipeline registers.
//   WORD_W      : datapath / PC width default
//   REG_ADDR_W  : architectural register specifier width
//   ALU_OP_W    : ALU operation code width default
//   alu_op_e    : ALU operation encodings produced by the decoder
//   ctrl_t      : single-bit control bundle carried from ID into EX
//   BUBBLE      : control bundle of a squashed/stalled slot (a NOP)
package mips_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_NOR = 4'h5,
    ALU_SLT = 4'h6,
    ALU_SLL = 4'h7,
    ALU_SRL = 4'h8,
    ALU_SRA = 4'h9,
    ALU_LUI = 4'hA
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic alu_src;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // Destination register: rd for R-type, rt for I-type.
  function automatic logic [REG_ADDR_W-1:0] sel_write_reg(
    input logic                  reg_dst,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rt
  );
    return reg_dst ? rd : rt;
  endfunction

endpackage

// File: rtl/load_use_hazard_detect.sv
// Load-use hazard detection for the ID/EX boundary (purely combinational).
//   ex_valid, ex_mem_read, ex_write_reg_addr : instruction currently in EX
//   id_valid, id_rs, id_rt, id_uses_rt       : instruction currently in ID
//   flush, ext_stall                         : higher-priority pipeline events
//   hazard          : raw dependency of ID on a load in EX
//   load_use_stall  : a bubble is inserted on this edge
//   pc_write        : PC may advance
//   if_id_write     : IF/ID may load
module load_use_hazard_detect
  import mips_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_write_reg_addr,
  input  logic                  id_valid,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  flush,
  input  logic                  ext_stall,
  output logic                  hazard,
  output logic                  load_use_stall,
  output logic                  pc_write,
  output logic                  if_id_write
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (ex_write_reg_addr == id_rs);
    rt_match = id_uses_rt && (ex_write_reg_addr == id_rt);
    // $0 is hardwired, so a load targeting it never creates a dependency.
    hazard = ex_valid && ex_mem_read && (ex_write_reg_addr != '0) &&
             id_valid && (rs_match || rt_match);
    // A flush already squashes the ID instruction, and a freeze holds
    // everything, so neither needs a load-use bubble.
    load_use_stall = hazard && !flush && !ext_stall;
    pc_write       = !ext_stall && !load_use_stall;
    if_id_write    = !ext_stall && !load_use_stall;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with integrated load-use hazard detection.
//   clk, reset (sync, active-high), ext_stall (freeze), flush (squash ID)
//   id_*   : decoded control, operands and register specifiers from ID
//   pc_write, if_id_write, load_use_stall : hazard outputs to IF/ID
//   ex_*   : registered values presented to EX and the forwarding unit
//   bubble_count : saturating count of load-use bubbles inserted
module id_ex_stage_reg
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = WORD_W,
  parameter int unsigned ALUOP_W = ALU_OP_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ext_stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic               id_uses_rt,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]  id_pc_plus4,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm_ext,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [4:0]         id_rd,
  input  logic [4:0]         id_shamt,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               load_use_stall,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]  ex_pc_plus4,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm_ext,
  output logic [4:0]         ex_rs,
  output logic [4:0]         ex_rt,
  output logic [4:0]         ex_shamt,
  output logic [4:0]         ex_write_reg_addr,
  output logic [CNT_W-1:0]   bubble_count
);

  ctrl_t ctrl_q;
  ctrl_t id_ctrl;
  logic  hazard;

  always_comb begin
    id_ctrl            = BUBBLE;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.alu_src    = id_alu_src;
  end

  load_use_hazard_detect u_hazard (
    .ex_valid          (ex_valid),
    .ex_mem_read       (ex_mem_read),
    .ex_write_reg_addr (ex_write_reg_addr),
    .id_valid          (id_valid),
    .id_uses_rt        (id_uses_rt),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .flush             (flush),
    .ext_stall         (ext_stall),
    .hazard            (hazard),
    .load_use_stall    (load_use_stall),
    .pc_write          (pc_write),
    .if_id_write       (if_id_write)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid          <= 1'b0;
      ctrl_q            <= BUBBLE;
      ex_alu_op         <= '0;
      ex_pc_plus4       <= '0;
      ex_rs_data        <= '0;
      ex_rt_data        <= '0;
      ex_imm_ext        <= '0;
      ex_rs             <= '0;
      ex_rt             <= '0;
      ex_shamt          <= '0;
      ex_write_reg_addr <= '0;
      bubble_count      <= '0;
    end else if (!ext_stall) begin
      // Operand and specifier fields load unconditionally; in a bubble
      // they are don't-care because every control bit is cleared.
      ex_pc_plus4 <= id_pc_plus4;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm_ext  <= id_imm_ext;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_shamt    <= id_shamt;
      if (flush || load_use_stall) begin
        ex_valid          <= 1'b0;
        ctrl_q            <= BUBBLE;
        ex_alu_op         <= '0;
        ex_write_reg_addr <= '0;
        if (load_use_stall && (bubble_count != '1)) begin
          bubble_count <= bubble_count + 1'b1;
        end
      end else if (id_valid) begin
        ex_valid          <= 1'b1;
        ctrl_q            <= id_ctrl;
        ex_alu_op         <= id_alu_op;
        ex_write_reg_addr <= sel_write_reg(id_reg_dst, id_rd, id_rt);
      end else begin
        ex_valid          <= 1'b0;
        ctrl_q            <= BUBBLE;
        ex_alu_op         <= '0;
        ex_write_reg_addr <= '0;
      end
    end
  end

  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_alu_src    = ctrl_q.alu_src;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg. A second instance with a 2-bit
// bubble counter shares all inputs so counter saturation is reachable.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        reset, ext_stall, flush, id_valid;
  logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
  logic        id_alu_src, id_reg_dst, id_uses_rt;
  logic [3:0]  id_alu_op;
  logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;

  logic        pc_write, if_id_write, load_use_stall;
  logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0]  ex_rs, ex_rt, ex_shamt, ex_write_reg_addr;
  logic [15:0] bubble_count;

  logic        s_pc_write, s_if_id_write, s_load_use_stall;
  logic        s_ex_valid, s_ex_reg_write, s_ex_mem_to_reg, s_ex_mem_read, s_ex_mem_write, s_ex_alu_src;
  logic [3:0]  s_ex_alu_op;
  logic [31:0] s_ex_pc_plus4, s_ex_rs_data, s_ex_rt_data, s_ex_imm_ext;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_shamt, s_ex_write_reg_addr;
  logic [1:0]  s_bubble_count;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(32), .ALUOP_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .flush(flush), .id_valid(id_valid),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_uses_rt(id_uses_rt), .id_alu_op(id_alu_op), .id_pc_plus4(id_pc_plus4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .pc_write(pc_write), .if_id_write(if_id_write), .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_shamt(ex_shamt), .ex_write_reg_addr(ex_write_reg_addr), .bubble_count(bubble_count)
  );

  id_ex_stage_reg #(.DATA_W(32), .ALUOP_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .flush(flush), .id_valid(id_valid),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_uses_rt(id_uses_rt), .id_alu_op(id_alu_op), .id_pc_plus4(id_pc_plus4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .load_use_stall(s_load_use_stall),
    .ex_valid(s_ex_valid), .ex_reg_write(s_ex_reg_write), .ex_mem_to_reg(s_ex_mem_to_reg),
    .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write), .ex_alu_src(s_ex_alu_src),
    .ex_alu_op(s_ex_alu_op), .ex_pc_plus4(s_ex_pc_plus4), .ex_rs_data(s_ex_rs_data),
    .ex_rt_data(s_ex_rt_data), .ex_imm_ext(s_ex_imm_ext), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt),
    .ex_shamt(s_ex_shamt), .ex_write_reg_addr(s_ex_write_reg_addr), .bubble_count(s_bubble_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model of the EX-side state ----------------
  logic        chk_en = 1'b0;
  logic        m_valid, m_rw, m_m2r, m_mr, m_mw, m_asrc;
  logic [3:0]  m_aluop;
  logic [4:0]  m_wr;
  logic        m_op_known;   // alu_op / write address defined
  logic        m_dat_known;  // operand / specifier fields defined
  logic [31:0] m_pc, m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_sh;
  int unsigned m_cnt, m_scnt;

  function automatic logic model_hz();
    if (!(m_valid && m_mr && m_wr != 5'd0 && id_valid)) return 1'b0;
    return (m_wr == id_rs) || (id_uses_rt && m_wr == id_rt);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      chk_en <= 1'b1;
      {m_valid, m_rw, m_m2r, m_mr, m_mw, m_asrc} <= '0;
      m_aluop <= '0; m_wr <= '0; m_op_known <= 1'b1; m_dat_known <= 1'b1;
      m_pc <= '0; m_rsd <= '0; m_rtd <= '0; m_imm <= '0;
      m_rs <= '0; m_rt <= '0; m_sh <= '0; m_cnt <= 0; m_scnt <= 0;
    end else if (!ext_stall) begin
      m_pc <= id_pc_plus4; m_rsd <= id_rs_data; m_rtd <= id_rt_data; m_imm <= id_imm_ext;
      m_rs <= id_rs; m_rt <= id_rt; m_sh <= id_shamt;
      if (flush || model_hz()) begin
        {m_valid, m_rw, m_m2r, m_mr, m_mw, m_asrc} <= '0;
        m_aluop <= '0; m_wr <= '0; m_op_known <= 1'b1; m_dat_known <= 1'b0;
        if (!flush) begin
          m_cnt  <= (m_cnt  == 65535) ? m_cnt  : m_cnt + 1;
          m_scnt <= (m_scnt == 3)     ? m_scnt : m_scnt + 1;
        end
      end else begin
        m_valid <= id_valid;
        m_rw  <= id_valid & id_reg_write;
        m_m2r <= id_valid & id_mem_to_reg;
        m_mr  <= id_valid & id_mem_read;
        m_mw  <= id_valid & id_mem_write;
        m_asrc <= id_valid & id_alu_src;
        m_aluop <= id_alu_op;
        m_wr <= id_reg_dst ? id_rd : id_rt;
        m_op_known <= id_valid;
        m_dat_known <= 1'b1;
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_lus;
      exp_lus = model_hz() && !flush && !ext_stall;
      chk("load_use_stall", load_use_stall, exp_lus);
      chk("pc_write", pc_write, !ext_stall && !exp_lus);
      chk("if_id_write", if_id_write, !ext_stall && !exp_lus);
      chk("ex_valid", ex_valid, m_valid);
      chk("ex_reg_write", ex_reg_write, m_rw);
      chk("ex_mem_to_reg", ex_mem_to_reg, m_m2r);
      chk("ex_mem_read", ex_mem_read, m_mr);
      chk("ex_mem_write", ex_mem_write, m_mw);
      chk("ex_alu_src", ex_alu_src, m_asrc);
      chk("bubble_count", bubble_count, m_cnt);
      chk("sat_bubble_count", s_bubble_count, m_scnt);
      chk("sat_ex_valid", s_ex_valid, m_valid);
      if (m_op_known) begin
        chk("ex_alu_op", ex_alu_op, m_aluop);
        chk("ex_write_reg_addr", ex_write_reg_addr, m_wr);
      end
      if (m_dat_known) begin
        chk("ex_pc_plus4", ex_pc_plus4, m_pc);
        chk("ex_rs_data", ex_rs_data, m_rsd);
        chk("ex_rt_data", ex_rt_data, m_rtd);
        chk("ex_imm_ext", ex_imm_ext, m_imm);
        chk("ex_rs", ex_rs, m_rs);
        chk("ex_rt", ex_rt, m_rt);
        chk("ex_shamt", ex_shamt, m_sh);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    id_pc_plus4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
    id_imm_ext = $urandom; id_shamt = 5'($urandom); id_rd = 5'($urandom);
    id_alu_op = 4'($urandom);
  endtask

  task automatic set_ctl(input logic v, rw, m2r, mr, mw, asrc, rdst, urt);
    id_valid = v; id_reg_write = rw; id_mem_to_reg = m2r; id_mem_read = mr;
    id_mem_write = mw; id_alu_src = asrc; id_reg_dst = rdst; id_uses_rt = urt;
  endtask

  task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
    rand_data(); set_ctl(1, 1, 1, 1, 0, 1, 0, 0); id_rs = rs; id_rt = rt;
  endtask

  task automatic add_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    rand_data(); set_ctl(1, 1, 0, 0, 0, 0, 1, 1); id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic addi(input logic [4:0] rs, input logic [4:0] rt);
    rand_data(); set_ctl(1, 1, 0, 0, 0, 1, 0, 0); id_rs = rs; id_rt = rt;
  endtask

  task automatic rand_all();
    rand_data();
    set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    id_rs = 5'($urandom); id_rt = 5'($urandom);
  endtask

  initial begin
    reset = 1'b1; ext_stall = 1'b0; flush = 1'b0;
    rand_all(); step();
    rand_all(); step();
    chk("reset ex_valid", ex_valid, 0);
    chk("reset bubble_count", bubble_count, 0);
    chk("reset pc_write", pc_write, 1);
    chk("reset ex_write_reg_addr", ex_write_reg_addr, 0);
    chk("reset ex_rs_data", ex_rs_data, 0);
    chk("model reset count", m_cnt, 0);

    // Normal flow
    reset = 1'b0;
    add_r(5'd1, 5'd7, 5'd5); id_rs_data = 32'h1234;
    step();
    chk("normal ex_write_reg_addr", ex_write_reg_addr, 5);
    chk("normal ex_rs_data", ex_rs_data, 32'h1234);
    chk("normal ex_valid", ex_valid, 1);
    chk("model normal wr", m_wr, 5);

    // Load-use on rs
    lw(5'd2, 5'd8); step();
    chk("lw ex_mem_read", ex_mem_read, 1);
    chk("lw ex_write_reg_addr", ex_write_reg_addr, 8);
    add_r(5'd8, 5'd3, 5'd9); #1;
    chk("rs hazard load_use_stall", load_use_stall, 1);
    chk("rs hazard pc_write", pc_write, 0);
    chk("rs hazard if_id_write", if_id_write, 0);
    step();
    chk("bubble ex_valid", ex_valid, 0);
    chk("bubble bubble_count", bubble_count, 1);
    chk("bubble ex_mem_read", ex_mem_read, 0);
    chk("after bubble stall drops", load_use_stall, 0);
    chk("model bubble count", m_cnt, 1);
    step();
    chk("held add enters ex_valid", ex_valid, 1);
    chk("held add ex_write_reg_addr", ex_write_reg_addr, 9);

    // rt match without rt use: no stall
    lw(5'd0, 5'd10); step();
    addi(5'd4, 5'd10); #1;
    chk("addi rt no stall", load_use_stall, 0);
    step();
    chk("addi ex_write_reg_addr", ex_write_reg_addr, 10);

    // Load to $0: no stall
    lw(5'd1, 5'd0); step();
    add_r(5'd0, 5'd0, 5'd11); #1;
    chk("load $0 no stall", load_use_stall, 0);
    step();

    // rt match with rt use: stall
    lw(5'd3, 5'd12); step();
    add_r(5'd1, 5'd12, 5'd13); #1;
    chk("rt hazard stall", load_use_stall, 1);
    step();
    chk("rt bubble count", bubble_count, 2);
    step();

    // Flush with simultaneous hazard
    lw(5'd2, 5'd13); step();
    add_r(5'd13, 5'd1, 5'd14); flush = 1'b1; #1;
    chk("flush stall suppressed", load_use_stall, 0);
    chk("flush pc_write", pc_write, 1);
    step();
    chk("flush bubble ex_valid", ex_valid, 0);
    chk("flush count unchanged", bubble_count, 2);
    flush = 1'b0;
    step();
    chk("post flush ex_write_reg_addr", ex_write_reg_addr, 14);

    // Invalid ID instruction cannot hazard; controls forced to 0
    lw(5'd2, 5'd15); step();
    add_r(5'd15, 5'd1, 5'd16); id_valid = 1'b0; #1;
    chk("invalid id no stall", load_use_stall, 0);
    step();
    chk("invalid ex_valid", ex_valid, 0);
    chk("invalid ex_reg_write", ex_reg_write, 0);

    // ext_stall for 3 cycles mid-hazard
    lw(5'd2, 5'd17); step();
    add_r(5'd17, 5'd2, 5'd18); ext_stall = 1'b1; #1;
    chk("ext_stall no lus", load_use_stall, 0);
    chk("ext_stall pc_write", pc_write, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frozen ex_mem_read", ex_mem_read, 1);
      chk("frozen ex_write_reg_addr", ex_write_reg_addr, 17);
      chk("frozen bubble_count", bubble_count, 2);
    end
    ext_stall = 1'b0; #1;
    chk("release stall", load_use_stall, 1);
    step();
    chk("release bubble ex_valid", ex_valid, 0);
    chk("release bubble_count", bubble_count, 3);
    chk("sat counter at max", s_bubble_count, 3);
    step();
    chk("release add enters", ex_write_reg_addr, 18);

    // One more bubble: small counter saturates, wide one increments
    lw(5'd4, 5'd19); step();
    add_r(5'd19, 5'd0, 5'd20); step();
    chk("wide count 4", bubble_count, 4);
    chk("sat counter holds", s_bubble_count, 3);
    chk("model sat count", m_scnt, 3);
    step();

    // Random mix on a narrow register window to provoke hazards
    for (int i = 0; i < 80; i++) begin
      rand_all();
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_valid  = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      ext_stall = ($urandom_range(0, 7) == 0);
      step();
    end
    flush = 1'b0; ext_stall = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
